// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter (uart_tx_buf).
// Optional parity is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Clock cycles occupied by one frame on the line.
    function automatic int unsigned frame_len(input int unsigned data_bits,
                                              input int unsigned stop_bits,
                                              input int unsigned cdiv,
                                              input bit          parity_en);
        return (1 + data_bits + (parity_en ? 1 : 0) + stop_bits) * cdiv;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Word FIFO in front of the UART serialiser: DEPTH x DATA_BITS, active-low write
// handshake, registered occupancy. Reads are look-ahead (o_data shows the head).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 2,
    localparam int LVL_W    = $clog2(DEPTH + 1),
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid_n,
    output logic                 o_ready_n,
    input  logic                 i_pop,
    output logic [DATA_BITS-1:0] o_data,
    output logic [LVL_W-1:0]     o_level
);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wp;
    logic [PTR_W-1:0]     r_rp;
    logic [LVL_W-1:0]     r_level;
    logic                 w_push;
    logic                 w_pop;

    // ready_n depends only on the registered level, so a pop cannot free a slot
    // for a push on the same edge.
    assign o_ready_n = (r_level == LVL_W'(DEPTH));
    assign w_push    = !i_valid_n && !o_ready_n;
    assign w_pop     = i_pop && (r_level != '0);
    assign o_data    = r_mem[r_rp];
    assign o_level   = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTR_W'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO plus LSB-first serialiser with registered line.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int CDIV       = 2,
    parameter int DEPTH      = 2,
    parameter int PARITY_ODD = 0,
    localparam int LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_n,
    output logic                 ready_n,
    output logic                 uart_tx,
    output logic                 busy,
    output logic [LVL_W-1:0]     level,
    output tx_state_t            dbg_state
);

    localparam int CNT_W = $clog2(STOP_BITS * CDIV + 1);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST_CNT  = CNT_W'(CDIV - 1);
    localparam logic [CNT_W-1:0] STOP_LAST_CNT = CNT_W'(STOP_BITS * CDIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT      = BIT_W'(DATA_BITS - 1);

    tx_state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [BIT_W-1:0]     r_bit, w_bit_nxt, w_bit_inc;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_par, w_par_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 w_load;
    logic                 w_pop;
    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_fifo_data;
    logic [LVL_W-1:0]     w_level;

    uart_tx_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_data    (data_in),
        .i_valid_n (valid_n),
        .o_ready_n (ready_n),
        .i_pop     (w_pop),
        .o_data    (w_fifo_data),
        .o_level   (w_level)
    );

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_bit_inc = r_bit + BIT_W'(1);
    assign w_bit_end = (r_cnt == BIT_LAST_CNT);

    // Next-state logic; the line value is computed one cycle ahead so uart_tx is a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt  = '0;
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                w_load     = (w_level != '0);
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = PARITY;
                        w_tx_nxt    = r_par;
`else
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_bit_nxt = w_bit_inc;
                        w_tx_nxt  = r_shift[w_bit_inc];
                    end
                end
            end
            PARITY: begin
                w_tx_nxt = r_par;
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                if (r_cnt == STOP_LAST_CNT) begin
                    if (w_level != '0) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                        w_tx_nxt    = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
        // Loading restarts bit timing so every frame is aligned to its own start bit.
        if (w_load) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
            w_cnt_nxt   = '0;
            w_shift_nxt = w_fifo_data;
            w_par_nxt   = (^w_fifo_data) ^ 1'(PARITY_ODD);
            w_tx_nxt    = 1'b0;
            w_busy_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign uart_tx   = r_tx;
    assign busy      = r_busy;
    assign level     = w_level;
    assign dbg_state = r_state;

endmodule
